// File: rtl/wb_pkg.sv
// Shared types and widths for the writeback arbiter and its load queue.
//   XLEN, REG_ADDR_W : data and register-address widths
//   wb_entry_t       : load-queue entry {rd, data, live}; live is cleared only
//                      when WB_ALU_KILL_EN is defined, otherwise it stays 1
//   wb_src_e         : per-cycle write-port source select
package wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
    logic                  live;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LQ,
    WB_BYP
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Load queue for the writeback arbiter: synchronous FIFO of wb_entry_t.
// Optional macro WB_ALU_KILL_EN adds a kill-by-rd port that clears the live
// bit of every stored entry whose rd matches kill_rd.
// Ports:
//   clk, reset            clock, async active-low reset (empties the queue)
//   push, push_entry      write an entry (ignored when full)
//   pop                   drop the head entry (ignored when empty)
//   head                  current head entry
//   full, empty, count    occupancy status
//   kill_en, kill_rd      (WB_ALU_KILL_EN only) mark matching entries dead
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
`ifdef WB_ALU_KILL_EN
  input  logic                  kill_en,
  input  logic [REG_ADDR_W-1:0] kill_rd,
`endif
  output wb_entry_t             head,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_W-1:0]      count
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; emptiness is tracked by the pointers/count.
  // A push into a slot overrides a same-cycle kill of that (free) slot.
  always_ff @(posedge clk) begin
`ifdef WB_ALU_KILL_EN
    if (kill_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem[i].rd == kill_rd) mem[i].live <= 1'b0;
      end
    end
`endif
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: sole driver of the register-file write port. Merges
// single-cycle ALU results (strict priority) with load results, which are
// buffered in a small queue until the port is free. Writes to x0 are dropped.
// Optional macro WB_ALU_KILL_EN: a winning ALU write to rd=R kills queued and
// same-cycle loads to R so an older load never overwrites a younger result.
// Ports:
//   clk, reset                        clock, async active-low reset
//   alu_valid, alu_rd, alu_data       ALU result (no backpressure)
//   ld_valid, ld_ready, ld_rd, ld_data load result handshake
//   rf_write_en, rf_dst_addr, rf_dst_data  registered register-file write
//   lq_count, busy                    load-queue occupancy
// XLEN and REG_ADDR_W come from wb_pkg; LQ_DEPTH must be a power of two >= 2.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter  int LQ_DEPTH = 4,
  localparam int CNT_W    = $clog2(LQ_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]       ld_data,
  output logic                  rf_write_en,
  output logic [REG_ADDR_W-1:0] rf_dst_addr,
  output logic [XLEN-1:0]       rf_dst_data,
  output logic [CNT_W-1:0]      lq_count,
  output logic                  busy
);

  wb_src_e    sel_src;
  wb_entry_t  push_entry;
  wb_entry_t  head;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic       alu_win;
  logic       ld_keep;

  // ld_ready looks only at full, never at a same-cycle pop.
  assign ld_ready = reset && !fifo_full;
  assign alu_win  = alu_valid && (alu_rd != '0);
  // x0 loads still handshake but go nowhere.
  assign ld_keep  = ld_valid && ld_ready && (ld_rd != '0);
  assign busy     = (lq_count != '0);

  always_comb begin
    sel_src    = WB_NONE;
    fifo_pop   = 1'b0;
    push_entry = '{rd: ld_rd, data: ld_data, live: 1'b1};
    if (alu_win) begin
      sel_src = WB_ALU;
    end else if (!fifo_empty) begin
      sel_src  = WB_LQ;
      fifo_pop = 1'b1;
    end else if (ld_keep) begin
      sel_src = WB_BYP;
    end
    fifo_push = ld_keep && (sel_src != WB_BYP);
`ifdef WB_ALU_KILL_EN
    if (alu_win && (ld_rd == alu_rd)) fifo_push = 1'b0;
`endif
  end

  wb_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
`ifdef WB_ALU_KILL_EN
    .kill_en    (alu_win),
    .kill_rd    (alu_rd),
`endif
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (lq_count)
  );

  // A dead head still consumes the port slot; addr/data hold like idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_write_en <= 1'b0;
      rf_dst_addr <= '0;
      rf_dst_data <= '0;
    end else begin
      case (sel_src)
        WB_ALU: begin
          rf_write_en <= 1'b1;
          rf_dst_addr <= alu_rd;
          rf_dst_data <= alu_data;
        end
        WB_LQ: begin
          rf_write_en <= head.live;
          if (head.live) begin
            rf_dst_addr <= head.rd;
            rf_dst_data <= head.data;
          end
        end
        WB_BYP: begin
          rf_write_en <= 1'b1;
          rf_dst_addr <= ld_rd;
          rf_dst_data <= ld_data;
        end
        default: rf_write_en <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        rf_write_en;
  logic [4:0]  rf_dst_addr;
  logic [31:0] rf_dst_data;
  logic [2:0]  lq_count;
  logic        busy;

  writeback_arbiter #(.LQ_DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_rd       (ld_rd),
    .ld_data     (ld_data),
    .rf_write_en (rf_write_en),
    .rf_dst_addr (rf_dst_addr),
    .rf_dst_data (rf_dst_data),
    .lq_count    (lq_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lr;
    logic [31:0] ldat;
    logic        e_rdy;
    logic        e_en;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    int          e_cnt;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vt[10];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ldat);
    alu_valid = av; alu_rd = ar; alu_data = ad;
    ld_valid  = lv; ld_rd  = lr; ld_data  = ldat;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
    wr_t w;
    w.rd = rd;
    w.data = data;
    exp_q.push_back(w);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 20 && (lq_count != 0 || exp_q.size() != 0); k++) @(negedge clk);
    #1;
    chk({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_lq_count"}, 64'(lq_count), 64'd0);
  endtask

  // Scoreboard: every register-file write must match the oldest expected one.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && rf_write_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: got write rd=%0d data=%0h expected no write",
                   rf_dst_addr, rf_dst_data);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          chk("sb_rd", 64'(rf_dst_addr), 64'(w.rd));
          chk("sb_data", 64'(rf_dst_data), 64'(w.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r;
    int   idx;

    //         av ar  ad            lv lr  ld     rdy en addr data          cnt
    vt[0] = '{1, 1,  32'hFFFFFFFF, 0, 0,  0,     1,  1, 1,  32'hFFFFFFFF, 0};
    vt[1] = '{1, 0,  32'h5,        0, 0,  0,     1,  0, 1,  32'hFFFFFFFF, 0};
    vt[2] = '{0, 0,  0,            1, 2,  2,     1,  1, 2,  32'h2,        0};
    vt[3] = '{1, 3,  3,            1, 4,  4,     1,  1, 3,  32'h3,        1};
    vt[4] = '{0, 0,  0,            0, 0,  0,     1,  1, 4,  32'h4,        0};
    vt[5] = '{0, 0,  0,            0, 0,  0,     1,  0, 4,  32'h4,        0};
    vt[6] = '{0, 0,  0,            1, 0,  9,     1,  0, 4,  32'h4,        0};
    vt[7] = '{1, 10, 32'h10,       1, 11, 'h11,  1,  1, 10, 32'h10,       1};
    vt[8] = '{0, 0,  0,            1, 12, 'h12,  1,  1, 11, 32'h11,       1};
    vt[9] = '{0, 0,  0,            0, 0,  0,     1,  1, 12, 32'h12,       0};

    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_write_en", 64'(rf_write_en), 64'd0);
    chk("rst_dst_addr", 64'(rf_dst_addr), 64'd0);
    chk("rst_dst_data", 64'(rf_dst_data), 64'd0);
    chk("rst_lq_count", 64'(lq_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ld_ready", 64'(ld_ready), 64'd0);
    #1 reset = 1'b1;

    // Table-driven single-cycle behaviour.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vt[i].av, vt[i].ar, vt[i].ad, vt[i].lv, vt[i].lr, vt[i].ldat);
      if (vt[i].e_en) expect_wr(vt[i].e_addr, vt[i].e_data);
      #1;
      chk($sformatf("v%0d_ld_ready", i), 64'(ld_ready), 64'(vt[i].e_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_write_en", i), 64'(rf_write_en), 64'(vt[i].e_en));
      chk($sformatf("v%0d_dst_addr", i), 64'(rf_dst_addr), 64'(vt[i].e_addr));
      chk($sformatf("v%0d_dst_data", i), 64'(rf_dst_data), 64'(vt[i].e_data));
      chk($sformatf("v%0d_lq_count", i), 64'(lq_count), 64'(vt[i].e_cnt));
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    drain("table");

    // Starvation: ALU holds the port while loads fill the queue.
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive(1, 5, 32'h500 + c, idx < 4, 5'(6 + idx), 32'h600 + idx);
      expect_wr(5, 32'h500 + c);
      #1;
      r = ld_ready;
      if (c == 4) begin
        chk("starve_lq_count", 64'(lq_count), 64'd4);
        chk("starve_ld_ready", 64'(ld_ready), 64'd0);
        chk("starve_busy", 64'(busy), 64'd1);
      end
      @(posedge clk);
      if (ld_valid && r) idx++;
    end
    for (int k = 0; k < 4; k++) expect_wr(5'(6 + k), 32'h600 + k);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    drain("starve");

    // Reset mid-stream with three loads queued behind the ALU.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(1, 14, 32'h1400 + c, 1, 5'(15 + c), 32'h1500 + c);
      expect_wr(14, 32'h1400 + c);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    chk("pre_rst_lq_count", 64'(lq_count), 64'd3);
    #2 reset = 1'b0;
    #1;
    chk("midrst_write_en", 64'(rf_write_en), 64'd0);
    chk("midrst_lq_count", 64'(lq_count), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ld_ready", 64'(ld_ready), 64'd0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("post_rst_pending", 64'(exp_q.size()), 64'd0);
    chk("post_rst_lq_count", 64'(lq_count), 64'd0);

    // Queued load to rd=7 followed by a younger ALU write to rd=7.
    @(negedge clk);
    drive(1, 16, 32'h16, 1, 7, 32'hA);
    expect_wr(16, 32'h16);
    @(negedge clk);
    drive(1, 7, 32'hB, 0, 0, 0);
    expect_wr(7, 32'hB);
`ifndef WB_ALU_KILL_EN
    expect_wr(7, 32'hA);
`endif
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1 chk("kill_lq_count", 64'(lq_count), 64'd1);
    drain("kill");
    repeat (3) @(negedge clk);
    #1 chk("final_pending", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Writeback stage directly upstream of the register file; sole driver of its write port (write_en/dst_addr/dst_data).
- Merges single-cycle ALU results with multi-cycle load results. ALU has strict priority; loads are buffered in a small FIFO until the port is free.
- Filters writes to x0, so the register file never sees them.

Parameters:
- XLEN, 32, data width.
- REG_ADDR_W, 5, register address width.
- LQ_DEPTH, 4, load-queue entries; power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = reset)
- alu_valid  in  1  ALU result present; no backpressure
- alu_rd  in  REG_ADDR_W  ALU destination
- alu_data  in  XLEN  ALU result
- ld_valid  in  1  load result offered
- ld_ready  out  1  load result accepted when ld_valid && ld_ready
- ld_rd  in  REG_ADDR_W  load destination
- ld_data  in  XLEN  load data
- rf_write_en  out  1  to register file write_en
- rf_dst_addr  out  REG_ADDR_W  to register file dst_addr
- rf_dst_data  out  XLEN  to register file dst_data
- lq_count  out  $clog2(LQ_DEPTH+1)  queued load entries
- busy  out  1  lq_count != 0

Behaviour:
- Reset (async assert, sync release): rf_write_en=0, rf_dst_addr=0, rf_dst_data=0, queue emptied, lq_count=0, busy=0. ld_ready=0 while reset is low.
- rf_* are registered. A result selected in cycle N appears on rf_* in cycle N+1 and is committed by the register file at the end of N+1, so latency from input to commit is 2 edges.
- ld_ready = !full. It does not depend on a same-cycle pop.
- x0 filter: alu_rd==0 is treated as alu_valid=0. A load with ld_rd==0 is handshaked normally but discarded (never enqueued, never written).
- Per-cycle selection, in priority order:
  1. ALU: if alu_valid and alu_rd!=0, write the ALU result.
  2. Queue head: otherwise, if the queue is non-empty, pop the head and write it.
  3. Bypass: otherwise, if a load handshake occurs with ld_rd!=0 and the queue is empty, write it directly without enqueueing.
  4. Idle: otherwise rf_write_en=0 next cycle; rf_dst_addr and rf_dst_data hold their last values.
- Enqueue: a handshaked load with ld_rd!=0 is enqueued unless it was bypassed in step 3.
  - Pop and enqueue in the same cycle are allowed.
  - The lq_count update is net: +1, -1 or 0.
- Ordering: queue entries are written in FIFO order. Upstream guarantees in-order issue, so any queued or same-cycle load is older than a concurrent ALU result.
- Starvation: continuous alu_valid starves the queue. The queue stalls at full via ld_ready=0, with no data loss.
- Reset mid-operation discards queued loads and any pending output write.

Optional Feature:
- Macro: WB_ALU_KILL_EN.
- Defined:
  - On a winning ALU write to rd=R, every queued entry with rd==R is marked dead.
  - A same-cycle incoming load with ld_rd==R is accepted and discarded.
  - Dead entries are still popped in order, but produce rf_write_en=0.
  - A dead head pop consumes that cycle's port slot; it does not fall through to bypass.
  - Result: an older load never overwrites a younger ALU result.
- Undefined: no per-entry valid bits. Upstream must not issue an ALU op whose rd matches an outstanding load (scoreboard responsibility).

Decomposition:
- Package wb_pkg holds:
  - XLEN and REG_ADDR_W constants.
  - typedef wb_entry_t {rd, data, live}; the live bit is used only under WB_ALU_KILL_EN.
  - typedef wb_src_e {WB_NONE, WB_ALU, WB_LQ, WB_BYP}.
- Sub-module wb_fifo: synchronous FIFO of wb_entry_t with depth LQ_DEPTH, full/empty/count outputs, and async active-low reset. Under WB_ALU_KILL_EN it adds a kill-by-rd port.

Test Plan:
- Reset, then alu_valid=1, alu_rd=1, alu_data=0xFFFFFFFF -> next cycle rf_write_en=1, rf_dst_addr=1, rf_dst_data=0xFFFFFFFF. Then alu_rd=0 -> rf_write_en=0.
- Load only, queue empty: ld_valid=1, ld_rd=2, ld_data=2 -> ld_ready=1, bypass, rf write {2,2} next cycle, lq_count stays 0.
- Simultaneous alu{rd=3,data=3} and ld{rd=4,data=4} -> write {3,3} then {4,4} on consecutive cycles. lq_count goes 1 then 0.
- Hold alu_valid with rd=5 for 6 cycles while offering loads rd=6..9 -> queue fills, ld_ready=0 at lq_count=4. After the ALU stops, writes occur in order 6,7,8,9.
- Three loads queued, then reset pulled low mid-stream -> rf_write_en=0 and lq_count=0 immediately. After release, no stale writes appear.
- WB_ALU_KILL_EN: queue ld{rd=7,data=0xA}, then alu{rd=7,data=0xB} -> only {7,0xB} is written. Without the macro, {7,0xB} then {7,0xA} are written.
